// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - kernel weight loader: ROM address sequencer with shadow/active double-buffered weight banks
// Optional build macro: WEIGHT_LOADER_AUTOSWAP_EN (auto-promote the first loaded set while the active bank is empty)
module weight_loader #(
  parameter int WIDTH          = 32,
  parameter int KERNEL_SIZE    = 3,
  parameter int WEIGHT_SET_NUM = 2,
  parameter int ADDR_WIDTH     = 5,
  parameter int SET_IDX_WIDTH  = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       i_start,
  input  logic [SET_IDX_WIDTH-1:0]                   i_set_idx,
  output logic [ADDR_WIDTH-1:0]                      o_rom_addr,
  input  logic [WIDTH-1:0]                           i_rom_data,
  input  logic                                       i_swap,
  output logic [WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]   o_weight,
  output logic                                       o_active_valid,
  output logic [SET_IDX_WIDTH-1:0]                   o_active_set,
  output logic                                       o_shadow_valid,
  output logic                                       o_busy,
  output logic                                       o_err
);

  localparam int NW    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int BANK_W = WIDTH * NW;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(NW - 1);
  localparam logic [ADDR_WIDTH-1:0] NW_A     = ADDR_WIDTH'(NW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [BANK_W-1:0]         shadow_q, shadow_d;
  logic [SET_IDX_WIDTH-1:0]  shadow_set_q, shadow_set_d;
  logic [BANK_W-1:0]         active_q, active_d;
  logic [SET_IDX_WIDTH-1:0]  active_set_q, active_set_d;
  logic                      active_valid_q, active_valid_d;
  logic                      shadow_valid_q, shadow_valid_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;

  logic                      idx_ok;
  logic                      swap_req;
  logic                      load_last;
  logic [ADDR_WIDTH-1:0]     base_addr;

  // Decode helpers: set-index range check, set base address, last-word flag, swap trigger
  always_comb begin
    idx_ok    = 32'(i_set_idx) < 32'(WEIGHT_SET_NUM);
    base_addr = ADDR_WIDTH'(i_set_idx) * NW_A;
    load_last = (cnt_q == CNT_LAST);
`ifdef WEIGHT_LOADER_AUTOSWAP_EN
    // With an empty active bank there is nothing for the array to lose, so promote immediately
    swap_req  = (state_q == FULL) && (i_swap || !active_valid_q);
`else
    swap_req  = (state_q == FULL) && i_swap;
`endif
  end

  // State and datapath registers; reset discards any partial load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      shadow_q       <= '0;
      shadow_set_q   <= '0;
      active_q       <= '0;
      active_set_q   <= '0;
      active_valid_q <= 1'b0;
      shadow_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      shadow_q       <= shadow_d;
      shadow_set_q   <= shadow_set_d;
      active_q       <= active_d;
      active_set_q   <= active_set_d;
      active_valid_q <= active_valid_d;
      shadow_valid_q <= shadow_valid_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start && idx_ok) state_d = LOAD;
      LOAD:    if (load_last)         state_d = FULL;
      FULL:    if (swap_req)          state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Datapath/output updates per state; a start outside IDLE is always rejected
  always_comb begin
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    shadow_d       = shadow_q;
    shadow_set_d   = shadow_set_q;
    active_d       = active_q;
    active_set_d   = active_set_q;
    active_valid_d = active_valid_q;
    shadow_valid_d = shadow_valid_q;
    busy_d         = busy_q;
    err_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (idx_ok) begin
            shadow_set_d = i_set_idx;
            addr_d       = base_addr;
            cnt_d        = '0;
            busy_d       = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // ROM data is combinational from the registered address, so it belongs to word cnt_q
        shadow_d[int'(cnt_q)*WIDTH +: WIDTH] = i_rom_data;
        if (i_start) err_d = 1'b1;
        if (load_last) begin
          cnt_d          = '0;
          addr_d         = '0;
          busy_d         = 1'b0;
          shadow_valid_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      FULL: begin
        if (i_start) err_d = 1'b1;
        if (swap_req) begin
          active_d       = shadow_q;
          active_set_d   = shadow_set_q;
          active_valid_d = 1'b1;
          shadow_valid_d = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign o_rom_addr     = addr_q;
  assign o_weight       = active_q;
  assign o_active_valid = active_valid_q;
  assign o_active_set   = active_set_q;
  assign o_shadow_valid = shadow_valid_q;
  assign o_busy         = busy_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - scoreboard testbench for weight_loader
module tb_weight_loader;
  localparam int WIDTH = 32;
  localparam int KS    = 3;
  localparam int NW    = KS * KS;
  localparam int AW    = 5;
  localparam int SW    = 2;
  localparam int BW    = WIDTH * NW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic [SW-1:0] i_set_idx = '0;
  logic          i_swap = 1'b0;
  logic [AW-1:0] o_rom_addr;
  logic [WIDTH-1:0] i_rom_data;
  logic [BW-1:0] o_weight;
  logic          o_active_valid;
  logic [SW-1:0] o_active_set;
  logic          o_shadow_valid;
  logic          o_busy;
  logic          o_err;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [BW-1:0] exp_bank_q[$];
  logic [SW-1:0] exp_set_q[$];
  logic [BW-1:0] exp_active = '0;
  logic [SW-1:0] exp_active_set = '0;

  weight_loader #(
    .WIDTH(WIDTH), .KERNEL_SIZE(KS), .WEIGHT_SET_NUM(2), .ADDR_WIDTH(AW), .SET_IDX_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_set_idx(i_set_idx),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data), .i_swap(i_swap),
    .o_weight(o_weight), .o_active_valid(o_active_valid), .o_active_set(o_active_set),
    .o_shadow_valid(o_shadow_valid), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  assign i_rom_data = 32'h1000 + 32'(o_rom_addr);

  function automatic logic [BW-1:0] set_words(input int s);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[k*WIDTH +: WIDTH] = 32'h1000 + 32'(s*NW + k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_rom_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", o_rom_addr); end
    checks++; if (o_weight !== '0) begin errors++; $display("FAIL reset_weight: got %0h expected 0", o_weight); end
    checks++; if ({o_active_valid, o_active_set, o_shadow_valid, o_busy, o_err} !== '0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0", {o_active_valid, o_active_set, o_shadow_valid, o_busy, o_err});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_set(input int s, input int err_at);
    logic [AW-1:0] ea;
    for (int k = 0; k < NW; k++) exp_addr_q.push_back(AW'(s*NW + k));
    exp_bank_q.push_back(set_words(s));
    exp_set_q.push_back(SW'(s));
    i_set_idx = SW'(s);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", o_busy); end
    for (int k = 0; k < NW; k++) begin
      ea = exp_addr_q.pop_front();
      checks++; if (o_rom_addr !== ea) begin errors++; $display("FAIL load_addr: got %0d expected %0d", o_rom_addr, ea); end
      checks++; if (o_weight !== exp_active) begin errors++; $display("FAIL active_stable: got %0h expected %0h", o_weight, exp_active); end
      if (k == err_at) i_start = 1'b1;
      tick();
      i_start = 1'b0;
      if (k == err_at) begin
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL load_start_err: got %b expected 1", o_err); end
      end
    end
    checks++; if (o_shadow_valid !== 1'b1) begin errors++; $display("FAIL load_shadow_valid: got %b expected 1", o_shadow_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL load_busy_done: got %b expected 0", o_busy); end
    checks++; if (o_rom_addr !== '0) begin errors++; $display("FAIL load_addr_done: got %0d expected 0", o_rom_addr); end
  endtask

  task automatic apply_swap(input bit use_swap);
    i_swap = use_swap;
    tick();
    i_swap = 1'b0;
    checks++;
    if (exp_bank_q.size() == 0) begin
      errors++; $display("FAIL swap_scoreboard: got empty queue expected one pending set");
    end else begin
      exp_active = exp_bank_q.pop_front();
      exp_active_set = exp_set_q.pop_front();
      if (o_weight !== exp_active) begin errors++; $display("FAIL swap_weight: got %0h expected %0h", o_weight, exp_active); end
    end
    checks++; if (o_active_set !== exp_active_set) begin errors++; $display("FAIL swap_set: got %0d expected %0d", o_active_set, exp_active_set); end
    checks++; if (o_active_valid !== 1'b1) begin errors++; $display("FAIL swap_active_valid: got %b expected 1", o_active_valid); end
    checks++; if (o_shadow_valid !== 1'b0) begin errors++; $display("FAIL swap_shadow_clear: got %b expected 0", o_shadow_valid); end
  endtask

  task automatic first_swap();
`ifdef WEIGHT_LOADER_AUTOSWAP_EN
    apply_swap(1'b0);
`else
    apply_swap(1'b1);
`endif
  endtask

  task automatic test_load_set0();
    load_set(0, -1);
    first_swap();
  endtask

  task automatic test_set1_swap_start();
    load_set(1, 4);
    for (int h = 0; h < 2; h++) begin
      tick();
      checks++; if (o_shadow_valid !== 1'b1 || o_weight !== exp_active) begin
        errors++; $display("FAIL full_hold: got sv=%b w=%0h expected sv=1 w=%0h", o_shadow_valid, o_weight, exp_active);
      end
    end
    i_swap = 1'b1;
    i_start = 1'b1;
    i_set_idx = 2'd0;
    tick();
    i_swap = 1'b0;
    i_start = 1'b0;
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL swap_start_err: got %b expected 1", o_err); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL swap_start_busy: got %b expected 0", o_busy); end
    exp_active = exp_bank_q.pop_front();
    exp_active_set = exp_set_q.pop_front();
    checks++; if (o_weight !== exp_active) begin errors++; $display("FAIL swap_start_weight: got %0h expected %0h", o_weight, exp_active); end
    checks++; if (o_active_set !== exp_active_set || o_shadow_valid !== 1'b0) begin
      errors++; $display("FAIL swap_start_flags: got set=%0d sv=%b expected set=%0d sv=0", o_active_set, o_shadow_valid, exp_active_set);
    end
    tick();
    checks++; if (o_err !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL swap_start_after: got err=%b busy=%b expected 0 0", o_err, o_busy);
    end
  endtask

  task automatic test_bad_idx();
    for (int idx = 2; idx < 4; idx++) begin
      i_set_idx = SW'(idx);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL bad_idx_err: got %b expected 1", o_err); end
      checks++; if (o_busy !== 1'b0 || o_rom_addr !== '0) begin
        errors++; $display("FAIL bad_idx_idle: got busy=%b addr=%0d expected 0 0", o_busy, o_rom_addr);
      end
      tick();
      checks++; if (o_err !== 1'b0 || o_busy !== 1'b0) begin
        errors++; $display("FAIL bad_idx_pulse: got err=%b busy=%b expected 0 0", o_err, o_busy);
      end
    end
  endtask

  task automatic test_swap_empty();
    i_swap = 1'b1;
    tick();
    i_swap = 1'b0;
    checks++; if (o_weight !== exp_active) begin errors++; $display("FAIL swap_empty_weight: got %0h expected %0h", o_weight, exp_active); end
    checks++; if (o_active_set !== exp_active_set || o_shadow_valid !== 1'b0) begin
      errors++; $display("FAIL swap_empty_flags: got set=%0d sv=%b expected set=%0d sv=0", o_active_set, o_shadow_valid, exp_active_set);
    end
  endtask

  task automatic test_back_to_back();
    load_set(1, -1);
    apply_swap(1'b1);
    load_set(0, -1);
    apply_swap(1'b1);
  endtask

  task automatic test_reset_mid_load();
    i_set_idx = 2'd1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    exp_active = '0;
    exp_active_set = '0;
    exp_addr_q.delete();
    exp_bank_q.delete();
    exp_set_q.delete();
    checks++; if (o_rom_addr !== '0 || o_weight !== '0) begin
      errors++; $display("FAIL midreset_data: got addr=%0d w=%0h expected 0 0", o_rom_addr, o_weight);
    end
    checks++; if ({o_active_valid, o_active_set, o_shadow_valid, o_busy, o_err} !== '0) begin
      errors++; $display("FAIL midreset_flags: got %b expected 0", {o_active_valid, o_active_set, o_shadow_valid, o_busy, o_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load_set(0, -1);
    first_swap();
  endtask

  initial begin
    test_reset();
    test_load_set0();
    test_set1_swap_start();
    test_bad_idx();
    test_swap_empty();
    test_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Downstream consumer of the weight ROM cache: sequences ROM addresses for one kernel weight set and captures KERNEL_SIZE*KERNEL_SIZE 32-bit words into a shadow bank.
- On command, transfers the shadow bank to an active bank that drives the convolution PE array with all kernel weights in parallel.
- Double buffering lets the next weight set load while the array computes with the current one.

Parameters:
- WIDTH, 32, weight word width in bits
- KERNEL_SIZE, 3, kernel edge length; a set holds KERNEL_SIZE*KERNEL_SIZE words (NW = 9 by default)
- WEIGHT_SET_NUM, 2, number of weight sets stored in the ROM
- ADDR_WIDTH, 5, ROM address width (32-deep ROM)
- SET_IDX_WIDTH, 1, width of the set-select input

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle request to load set i_set_idx into the shadow bank
- i_set_idx  input  SET_IDX_WIDTH  weight set to load, sampled with i_start
- o_rom_addr  output  ADDR_WIDTH  ROM read address, registered
- i_rom_data  input  WIDTH  ROM read data, combinational from o_rom_addr
- i_swap  input  1  consumer request to move shadow to active
- o_weight  output  WIDTH*NW  active-bank weights; word k is at bits [k*WIDTH +: WIDTH], with k = row*KERNEL_SIZE+col
- o_active_valid  output  1  active bank holds a complete set
- o_active_set  output  SET_IDX_WIDTH  set index held in the active bank
- o_shadow_valid  output  1  shadow bank full, awaiting swap
- o_busy  output  1  loading in progress
- o_err  output  1  one-cycle pulse when an i_start is rejected

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; o_rom_addr=0, o_weight=0, both banks 0, o_active_valid=0, o_active_set=0, o_shadow_valid=0, o_busy=0, o_err=0, word counter 0. This applies mid-load too: a partial load is discarded.
- States: IDLE, LOAD, FULL.
- IDLE:
  - i_start with i_set_idx < WEIGHT_SET_NUM: latch the set index, set base = i_set_idx*NW, o_rom_addr<=base, cnt<=0, o_busy<=1, go to LOAD.
  - i_set_idx >= WEIGHT_SET_NUM: o_err pulses for 1 cycle, stay in IDLE.
- LOAD:
  - Each cycle: shadow[cnt]<=i_rom_data (ROM data corresponding to the current registered o_rom_addr); cnt<=cnt+1; o_rom_addr<=o_rom_addr+1.
  - When cnt==NW-1: capture the last word, o_rom_addr<=0, o_busy<=0, o_shadow_valid<=1, go to FULL.
  - Load takes exactly NW cycles after the i_start edge; o_shadow_valid rises on edge NW+1 counted from the i_start edge (edge 1).
- FULL:
  - i_swap: active<=shadow, o_active_set<=shadow set index, o_active_valid<=1, o_shadow_valid<=0, go to IDLE. o_weight changes on that edge.
- i_start while in LOAD or FULL: ignored and o_err pulses. In FULL, if i_start and i_swap arrive in the same cycle, the swap happens and i_start is still rejected; the consumer must re-issue it.
- i_swap while o_shadow_valid=0: ignored; the active bank is unchanged.
- The active bank is never modified during LOAD. o_weight stays stable except at a swap edge.
- Address arithmetic: base+cnt <= WEIGHT_SET_NUM*NW-1, which must be <= 2^ADDR_WIDTH-1. With defaults this is 17 <= 31. Generation of base and addresses uses no wrap.
- All outputs are registered; there is no combinational path from an input to an output.

Optional Feature:
- Macro WEIGHT_LOADER_AUTOSWAP_EN.
- Defined: in FULL with o_active_valid=0, the swap happens automatically on the next edge without i_swap. This covers the first load after reset. Once o_active_valid=1, only i_swap triggers a swap.
- Undefined: a swap happens only on i_swap.

Test Plan:
- ROM word at addr a = 0x1000+a; reset, i_start with set 0 -> o_rom_addr steps 0..8. After the swap, o_weight word k = 0x1000+k for k=0..8, o_active_set=0, o_active_valid=1.
- i_start set 1 while active holds set 0 -> o_rom_addr steps 9..17 and o_weight stays set 0 throughout the load. On i_swap, words = 0x1009..0x1011 and o_active_set=1.
- i_start with set index 2 (requires SET_IDX_WIDTH=2, WEIGHT_SET_NUM=2) -> o_err pulses 1 cycle, state stays IDLE, o_busy=0. Also: i_start during LOAD at cnt=4 -> o_err pulse, load completes unaffected.
- In FULL, drive i_swap and i_start in the same cycle -> swap occurs, o_err=1, o_shadow_valid=0. i_swap with o_shadow_valid=0 -> o_weight unchanged.
- Deassert rst_n at cnt=5 of a load -> all outputs go to 0 asynchronously. A new load of set 0 then completes normally with the correct words.
- With WEIGHT_LOADER_AUTOSWAP_EN: first load after reset -> o_active_valid=1 one cycle after o_shadow_valid rises, with no i_swap. A second load stays in FULL until i_swap.
